// File: rtl/huff_pkg.sv
// Shared types and constants for the Huffman tree-build controller.
// Node word layout (shared with the external sorter): [12:5] weight, [4:0] id.
package huff_pkg;

    localparam int NODE_W   = 13;
    localparam int WT_W     = 8;
    localparam int ID_W     = 5;
    localparam int NUM_LEAF = 8;
    localparam int NUM_ENT  = 15;
    localparam int TBL_W    = 2 * ID_W + WT_W;

    localparam logic [ID_W-1:0] DUMMY_ID = 5'h1F;
    localparam logic [WT_W-1:0] WT_SAT   = 8'hFE;
    localparam logic [WT_W-1:0] WT_DUMMY = 8'hFF;
    localparam logic [ID_W-1:0] ROOT_ID  = 5'd14;

    typedef struct packed {
        logic [WT_W-1:0] wt;
        logic [ID_W-1:0] id;
    } node_t;

    typedef struct packed {
        logic [ID_W-1:0] left;
        logic [ID_W-1:0] right;
        logic [WT_W-1:0] wt;
    } tbl_entry_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SORT,
        S_WAIT,
        S_SETTLE,
        S_MERGE,
        S_DONE
    } state_t;

    localparam node_t DUMMY_NODE = '{wt: WT_DUMMY, id: DUMMY_ID};

    // Saturating parent-weight add: returns {saturated, weight}.
    // Capping at 0xFE keeps every real parent strictly lighter than a dummy.
    function automatic logic [WT_W:0] sat_add(input logic [WT_W-1:0] a,
                                              input logic [WT_W-1:0] b);
        logic [WT_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum > {1'b0, WT_SAT}) begin
            sat_add = {1'b1, WT_SAT};
        end else begin
            sat_add = {1'b0, sum[WT_W-1:0]};
        end
    endfunction

endpackage

// File: rtl/huff_tree_tbl.sv
// 15 x 18 tree table: one merge write port, a bulk leaf-load port that also
// clears the parent rows, and a registered read port (1-cycle latency).
module huff_tree_tbl
    import huff_pkg::*;
(
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     ld_i,
    input  logic [NUM_LEAF*WT_W-1:0] ld_w_i,
    input  logic                     we_i,
    input  logic [3:0]               waddr_i,
    input  tbl_entry_t               wdata_i,
    input  logic [3:0]               raddr_i,
    output tbl_entry_t               rdata_o
);

    localparam logic [3:0] LAST_ADDR = 4'(NUM_ENT - 1);

    tbl_entry_t mem_q [NUM_ENT];
    tbl_entry_t rdata_q;

    // Storage: leaf rows get {no child, no child, weight}; parent rows are
    // zeroed on load so a new build never shows a stale tree.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < NUM_ENT; i++) begin
                mem_q[i] <= '0;
            end
        end else if (ld_i) begin
            for (int i = 0; i < NUM_ENT; i++) begin
                if (i < NUM_LEAF) begin
                    mem_q[i] <= '{left: DUMMY_ID, right: DUMMY_ID,
                                  wt: ld_w_i[i*WT_W +: WT_W]};
                end else begin
                    mem_q[i] <= '0;
                end
            end
        end else if (we_i && (waddr_i <= LAST_ADDR)) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Registered read; addresses past the last row read as zero.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rdata_q <= '0;
        end else if (raddr_i <= LAST_ADDR) begin
            rdata_q <= mem_q[raddr_i];
        end else begin
            rdata_q <= '0;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/huff_merge_ctrl.sv
// Huffman tree-build sequencer: loads 8 leaves, then runs seven
// sort/merge rounds against the external node sorter, recording each
// merge in the tree table. GUARD and SETTLE must both be at least 1.
module huff_merge_ctrl
    import huff_pkg::*;
#(
    parameter int SETTLE = 2,
    parameter int GUARD  = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic [63:0]       leaf_w,
    output logic              busy,
    output logic              done,
    output logic [4:0]        root_id,
    output logic              ovf,
    output logic              err,
    output logic [2:0]        merge_cnt,
    output logic              srt_start,
    output logic [12:0]       srt_node0,
    output logic [12:0]       srt_node1,
    output logic [12:0]       srt_node2,
    output logic [12:0]       srt_node3,
    output logic [12:0]       srt_node4,
    output logic [12:0]       srt_node5,
    output logic [12:0]       srt_node6,
    output logic [12:0]       srt_node7,
    input  logic [12:0]       srt_new1,
    input  logic [12:0]       srt_new2,
    input  logic [12:0]       srt_new3,
    input  logic [12:0]       srt_new4,
    input  logic [12:0]       srt_new5,
    input  logic [12:0]       srt_new6,
    input  logic [12:0]       srt_new7,
    input  logic [12:0]       srt_new8,
    input  logic              srt_done,
    input  logic [3:0]        tbl_addr,
    output logic [17:0]       tbl_data
);

    // The SORT cycle counts as the first guard cycle, so srt_done is first
    // looked at in WAIT cycle GUARD-1.
    localparam logic [7:0] G_LAST = 8'(GUARD - 1);
    localparam logic [7:0] S_LAST = 8'(SETTLE - 1);

    state_t            state_q;
    logic [7:0]        cnt_q;
    logic [2:0]        merge_cnt_q;
    logic              busy_q, done_q, srt_start_q, ovf_q, err_q;
    logic [ID_W-1:0]   root_q;
    node_t             node_q [NUM_LEAF];
    node_t             new_w  [NUM_LEAF];

    logic [WT_W:0]     sum_sat;
    node_t             parent;
    logic              dummy_hit;
    tbl_entry_t        wr_ent;
    tbl_entry_t        rd_ent;
    logic [3:0]        waddr;

    assign new_w[0] = srt_new1;
    assign new_w[1] = srt_new2;
    assign new_w[2] = srt_new3;
    assign new_w[3] = srt_new4;
    assign new_w[4] = srt_new5;
    assign new_w[5] = srt_new6;
    assign new_w[6] = srt_new7;
    assign new_w[7] = srt_new8;

    // Parent formed from the two lightest sorter outputs.
    always_comb begin
        sum_sat   = sat_add(new_w[0].wt, new_w[1].wt);
        parent    = '{wt: sum_sat[WT_W-1:0],
                      id: ID_W'(NUM_LEAF) + {2'b00, merge_cnt_q}};
        dummy_hit = (new_w[0].id == DUMMY_ID) || (new_w[1].id == DUMMY_ID);
        wr_ent    = '{left: new_w[0].id, right: new_w[1].id, wt: sum_sat[WT_W-1:0]};
        waddr     = 4'(NUM_LEAF) + {1'b0, merge_cnt_q};
    end

    huff_tree_tbl u_tbl (
        .CLK     (CLK),
        .RST     (RST),
        .ld_i    (state_q == S_LOAD),
        .ld_w_i  (leaf_w),
        .we_i    (state_q == S_MERGE),
        .waddr_i (waddr),
        .wdata_i (wr_ent),
        .raddr_i (tbl_addr),
        .rdata_o (rd_ent)
    );

    // Sequencer with registered outputs; srt_start and done are single-cycle
    // pulses asserted on entry to SORT and DONE respectively.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            merge_cnt_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            srt_start_q <= 1'b0;
            ovf_q       <= 1'b0;
            err_q       <= 1'b0;
            root_q      <= '0;
            for (int i = 0; i < NUM_LEAF; i++) begin
                node_q[i] <= '0;
            end
        end else begin
            srt_start_q <= 1'b0;
            done_q      <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_LOAD;
                        busy_q  <= 1'b1;
                    end
                end
                S_LOAD: begin
                    for (int i = 0; i < NUM_LEAF; i++) begin
                        node_q[i] <= '{wt: leaf_w[i*WT_W +: WT_W], id: ID_W'(i)};
                    end
                    merge_cnt_q <= '0;
                    ovf_q       <= 1'b0;
                    err_q       <= 1'b0;
                    root_q      <= '0;
                    srt_start_q <= 1'b1;
                    state_q     <= S_SORT;
                end
                S_SORT: begin
                    cnt_q   <= '0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    // A done level left over from the previous sort is
                    // masked until the guard window has passed.
                    if (cnt_q >= G_LAST) begin
                        if (srt_done) begin
                            cnt_q   <= '0;
                            state_q <= S_SETTLE;
                        end
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                S_SETTLE: begin
                    if (cnt_q >= S_LAST) begin
                        state_q <= S_MERGE;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                S_MERGE: begin
                    node_q[0] <= parent;
                    for (int i = 1; i < NUM_LEAF - 1; i++) begin
                        node_q[i] <= new_w[i+1];
                    end
                    node_q[NUM_LEAF-1] <= DUMMY_NODE;
                    merge_cnt_q <= merge_cnt_q + 3'd1;
                    ovf_q       <= ovf_q | sum_sat[WT_W];
                    err_q       <= err_q | dummy_hit;
                    if (merge_cnt_q == 3'd6) begin
                        root_q  <= ROOT_ID;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        srt_start_q <= 1'b1;
                        state_q     <= S_SORT;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign root_id   = root_q;
    assign ovf       = ovf_q;
    assign err       = err_q;
    assign merge_cnt = merge_cnt_q;
    assign srt_start = srt_start_q;
    assign srt_node0 = node_q[0];
    assign srt_node1 = node_q[1];
    assign srt_node2 = node_q[2];
    assign srt_node3 = node_q[3];
    assign srt_node4 = node_q[4];
    assign srt_node5 = node_q[5];
    assign srt_node6 = node_q[6];
    assign srt_node7 = node_q[7];
    assign tbl_data  = rd_ent;

endmodule

// File: tb/tb_huff_merge_ctrl.sv
// Bench for huff_merge_ctrl: behavioural sorter responder plus a
// list-based Huffman reference model of the expected tree table.
module tb_huff_merge_ctrl;

    localparam logic [12:0] DUMMY = {8'hFF, 5'h1F};

    logic              CLK = 1'b0;
    logic              RST, start;
    logic [63:0]       leaf_w;
    logic              busy, done, ovf, err, srt_start, srt_done;
    logic [4:0]        root_id;
    logic [2:0]        merge_cnt;
    wire  [7:0][12:0]  nd;
    logic [7:0][12:0]  nw;
    logic [3:0]        tbl_addr;
    logic [17:0]       tbl_data;

    bit inj_en, rnd_dly;
    int sd_cnt;
    int npass = 0, nfail = 0, ntot = 0;

    huff_merge_ctrl #(.SETTLE(2), .GUARD(2)) dut (
        .CLK(CLK), .RST(RST), .start(start), .leaf_w(leaf_w),
        .busy(busy), .done(done), .root_id(root_id), .ovf(ovf), .err(err),
        .merge_cnt(merge_cnt), .srt_start(srt_start),
        .srt_node0(nd[0]), .srt_node1(nd[1]), .srt_node2(nd[2]), .srt_node3(nd[3]),
        .srt_node4(nd[4]), .srt_node5(nd[5]), .srt_node6(nd[6]), .srt_node7(nd[7]),
        .srt_new1(nw[0]), .srt_new2(nw[1]), .srt_new3(nw[2]), .srt_new4(nw[3]),
        .srt_new5(nw[4]), .srt_new6(nw[5]), .srt_new7(nw[6]), .srt_new8(nw[7]),
        .srt_done(srt_done), .tbl_addr(tbl_addr), .tbl_data(tbl_data)
    );

    always #5 CLK = ~CLK;

    // Stable ascending sort by weight (ties keep input order).
    function automatic logic [7:0][12:0] sort8(input logic [7:0][12:0] a);
        logic [7:0][12:0] r;
        logic [12:0] t;
        r = a;
        for (int i = 1; i < 8; i++)
            for (int j = i; j > 0; j--)
                if (r[j][12:5] < r[j-1][12:5]) begin
                    t = r[j]; r[j] = r[j-1]; r[j-1] = t;
                end
        return r;
    endfunction

    function automatic logic [7:0][12:0] inject(input logic [7:0][12:0] a, input bit en);
        logic [7:0][12:0] r;
        r = a;
        if (en) r[1] = DUMMY;
        return r;
    endfunction

    // Sorter responder: done drops on start, rises 2 cycles later plus an
    // optional random extra delay.
    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            srt_done <= 1'b0;
            sd_cnt   <= 0;
            nw       <= '0;
        end else if (srt_start) begin
            nw       <= inject(sort8(nd), inj_en && merge_cnt == 3'd2);
            srt_done <= 1'b0;
            sd_cnt   <= 1 + (rnd_dly ? int'($urandom_range(0, 3)) : 0);
        end else if (sd_cnt > 0) begin
            sd_cnt <= sd_cnt - 1;
            if (sd_cnt == 1) srt_done <= 1'b1;
        end
    end

    // Reference tree build: repeatedly pair the two lightest list entries.
    task automatic model(input logic [63:0] w, input bit inj,
                         output logic [14:0][17:0] et, output logic eovf, output logic eerr);
        logic [7:0][12:0] lst, s;
        logic [7:0] pw;
        int sum;
        eovf = 0; eerr = 0; et = '0;
        for (int i = 0; i < 8; i++) begin
            lst[i] = {w[8*i +: 8], 5'(i)};
            et[i]  = {5'h1F, 5'h1F, w[8*i +: 8]};
        end
        for (int m = 0; m < 7; m++) begin
            s   = inject(sort8(lst), inj && m == 2);
            sum = int'(s[0][12:5]) + int'(s[1][12:5]);
            if (sum > 254) begin pw = 8'hFE; eovf = 1; end
            else pw = 8'(sum);
            if (s[0][4:0] == 5'h1F || s[1][4:0] == 5'h1F) eerr = 1;
            et[8+m] = {s[0][4:0], s[1][4:0], pw};
            lst[0] = {pw, 5'(8 + m)};
            for (int k = 1; k < 7; k++) lst[k] = s[k+1];
            lst[7] = DUMMY;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One complete build; call at #1 after a rising edge.
    task automatic run_build(input string nm, input logic [63:0] w, input bit inj,
                             input bit rnd, input bit dbl);
        logic [14:0][17:0] et;
        logic eovf, eerr;
        int n, ndone, nbusy;
        model(w, inj, et, eovf, eerr);
        inj_en = inj; rnd_dly = rnd; leaf_w = w; start = 1'b1;
        n = 0;
        do begin
            @(posedge CLK); #1; n++;
            start = dbl && (n == 10 || n == 30);
        end while (!done && n < 3000);
        start = 1'b0;
        chk($sformatf("%s done", nm), 32'(done), 1);
        if (!rnd) chk($sformatf("%s latency", nm), n, 44);
        chk($sformatf("%s root_id", nm), 32'(root_id), 14);
        chk($sformatf("%s merge_cnt", nm), 32'(merge_cnt), 7);
        chk($sformatf("%s busy@done", nm), 32'(busy), 0);
        chk($sformatf("%s ovf", nm), 32'(ovf), 32'(eovf));
        chk($sformatf("%s err", nm), 32'(err), 32'(eerr));
        @(posedge CLK); #1;
        chk($sformatf("%s done pulse", nm), 32'(done), 0);
        ndone = 0; nbusy = 0;
        for (int a = 0; a < 15; a++) begin
            tbl_addr = 4'(a);
            @(posedge CLK); #1;
            ndone += int'(done); nbusy += int'(busy);
            chk($sformatf("%s tbl[%0d]", nm, a), 32'(tbl_data), 32'(et[a]));
        end
        if (dbl) begin
            for (int c = 0; c < 40; c++) begin
                @(posedge CLK); #1;
                ndone += int'(done); nbusy += int'(busy);
            end
            chk($sformatf("%s extra done", nm), ndone, 0);
            chk($sformatf("%s rebuild busy", nm), nbusy, 0);
        end
        chk($sformatf("%s ovf sticky", nm), 32'(ovf), 32'(eovf));
        chk($sformatf("%s err sticky", nm), 32'(err), 32'(eerr));
    endtask

    initial begin : main
        int n;
        RST = 1'b1; start = 1'b0; leaf_w = '0; tbl_addr = '0;
        inj_en = 0; rnd_dly = 0;
        #2;
        chk("reset busy", 32'(busy), 0);
        chk("reset done", 32'(done), 0);
        chk("reset root_id", 32'(root_id), 0);
        chk("reset ovf_err", {30'b0, ovf, err}, 0);
        chk("reset merge_cnt", 32'(merge_cnt), 0);
        chk("reset srt_start", 32'(srt_start), 0);
        chk("reset nodes", 32'(|nd), 0);
        chk("reset tbl_data", 32'(tbl_data), 0);
        @(posedge CLK); @(posedge CLK); #1;
        RST = 1'b0;
        @(posedge CLK); #1;
        chk("idle tbl[9]", 32'(tbl_data), 0);

        run_build("w1to8", 64'h0807060504030201, 0, 0, 0);
        chk("w1to8 tbl[8] const", 32'(tbl_data), 32'(tbl_data));
        ntot--; npass--;
        tbl_addr = 4'd8; @(posedge CLK); #1;
        chk("w1to8 tbl[8]", 32'(tbl_data), 32'({5'd0, 5'd1, 8'd3}));
        tbl_addr = 4'd14; @(posedge CLK); #1;
        chk("w1to8 tbl[14].wt", 32'(tbl_data[7:0]), 36);

        run_build("all50", {8{8'h50}}, 0, 0, 0);
        run_build("all0", 64'h0, 0, 0, 0);
        run_build("inject", {$urandom, $urandom}, 1, 0, 0);

        // Reset during the 4th WAIT, then rebuild from a fresh start.
        tbl_addr = 4'd0; leaf_w = 64'h1122334455667788; start = 1'b1;
        @(posedge CLK); #1; start = 1'b0;
        n = 0;
        while (!(srt_start && merge_cnt == 3'd3) && n < 1000) begin
            @(posedge CLK); #1; n++;
        end
        chk("midrst reach 4th sort", 32'(srt_start && merge_cnt == 3'd3), 1);
        @(posedge CLK); #1;
        RST = 1'b1; #1;
        chk("midrst busy", 32'(busy), 0);
        chk("midrst srt_start", 32'(srt_start), 0);
        chk("midrst merge_cnt", 32'(merge_cnt), 0);
        chk("midrst nodes", 32'(|nd), 0);
        chk("midrst tbl_data", 32'(tbl_data), 0);
        @(posedge CLK); @(posedge CLK); #1;
        RST = 1'b0;
        for (int c = 0; c < 5; c++) begin @(posedge CLK); #1; end
        chk("midrst no restart", 32'(busy), 0);
        chk("midrst tbl cleared", 32'(tbl_data), 0);
        run_build("postrst", {$urandom, $urandom}, 0, 1, 0);

        run_build("dblstart", {$urandom, $urandom}, 0, 0, 1);
        for (int r = 0; r < 3; r++)
            run_build($sformatf("rand%0d", r), {$urandom, $urandom}, 0, 1, 0);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
